mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of the MEM-stage byte address.
REQ-002 Parameter DATA_W, default 32, width of the MEM-stage data word.
REQ-003 Parameter WAIT_CYCLES, default 5, number of clock cycles each SRAM half-word access is held (legal range 1..15).
REQ-004 Parameter BASE_ADDR, default 1024, byte address that maps to SRAM word 0.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 mem_read_in  input  1  load request from the MEM stage.
REQ-008 mem_write_in  input  1  store request from the MEM stage.
REQ-009 alu_res_in  input  ADDR_W  byte address of the access.
REQ-010 val_rm_in  input  DATA_W  store data.
REQ-011 ready  output  1  access finished or no access pending; the pipeline freezes while this is 0.
REQ-012 data_mem_out  output  DATA_W  load result; valid when ready=1 in the DONE state.
REQ-013 sram_addr  output  18  SRAM half-word address.
REQ-014 sram_wdata  output  16  SRAM write data.
REQ-015 sram_rdata  input  16  SRAM read data.
REQ-016 sram_we_n  output  1  SRAM write enable, active-low.
REQ-017 sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-018 The block SHALL implement FSM states IDLE, LO, HI and DONE.
REQ-019 In IDLE, req = mem_read_in | mem_write_in SHALL move the FSM to LO and latch the address, the store data and the operation type.
REQ-020 If both mem_read_in and mem_write_in are 1, the block SHALL perform a write.
REQ-021 The word index SHALL be idx = (alu_res_in - BASE_ADDR) >> 2, truncated to 17 bits.
- LO SHALL drive sram_addr = {idx,0}.
- HI SHALL drive sram_addr = {idx,1}.
REQ-022 LO and HI SHALL each last exactly WAIT_CYCLES cycles, counted by a 4-bit counter that clears on each state entry.
REQ-023 Writes:
- sram_we_n SHALL be 0 throughout LO and HI.
- sram_wdata SHALL be data[15:0] in LO and data[31:16] in HI.
REQ-024 Reads:
- sram_oe_n SHALL be 0 throughout LO and HI.
- sram_rdata SHALL be captured on the last cycle of LO into the low half and on the last cycle of HI into the high half of the read register.
REQ-025 After HI, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-026 ready SHALL be combinational:
- 1 in DONE.
- 1 in IDLE with req=0.
- 0 otherwise.
- Total stall SHALL therefore be 1 + 2*WAIT_CYCLES cycles per access.
REQ-027 data_mem_out SHALL hold the last completed read value until the next read completes; writes SHALL NOT change it.
REQ-028 Deasserting req during LO or HI SHALL NOT abort the access; it completes with the latched operands.
REQ-029 A req present in the cycle after DONE SHALL start a new access; back-to-back accesses SHALL have no extra idle cycle.
REQ-030 Outside LO and HI, sram_we_n and sram_oe_n SHALL be 1, sram_addr SHALL be 0 and sram_wdata SHALL be 0.

Reset
REQ-031 rst=1 SHALL immediately force:
- state IDLE and counter 0;
- sram_we_n=1, sram_oe_n=1;
- data_mem_out=0.
REQ-032 Reset during LO or HI SHALL abandon the access with no further SRAM strobe.
REQ-033 After reset, ready SHALL equal ~req.

Structure
REQ-034 The FSM state encoding, the SRAM widths (18/16) and BASE_ADDR SHALL live in a shared package alongside the existing ADDRESS_LEN and REGISTER_LEN defines.
REQ-035 The wait counter SHALL be a sub-module named wait_counter, with inputs clear and enable and output done.
REQ-036 The MEM stage SHALL instantiate mem_access_ctrl in place of its direct memory instance and route ~ready to the pipeline freeze.

Verification
REQ-037 Write 0xDEADBEEF to address 1024 with WAIT_CYCLES=5 -> required response:
- ready=0 for 11 cycles;
- we_n=0 with sram_addr=0, wdata=0xBEEF for 5 cycles;
- then sram_addr=1, wdata=0xDEAD for 5 cycles;
- then ready=1 for one cycle.
REQ-038 Read address 1028 with the SRAM model returning 0x5678 at address 2 and 0x1234 at address 3 -> data_mem_out=0x12345678 in DONE, and it holds afterwards.
REQ-039 Read and write both asserted at address 1032 with val_rm_in=0xA5A5 0F0F -> a write occurs (we_n=0, sram_addr=4 then 5) and data_mem_out is unchanged.
REQ-040 Two back-to-back reads -> the second access enters LO on the cycle after DONE; ready pulses high for exactly 1 cycle between the accesses.
REQ-041 rst asserted on the 3rd cycle of HI during a write -> we_n=1 immediately, state IDLE, data_mem_out=0, ready=1 with req=0.
REQ-042 req dropped on the 2nd cycle of LO -> the access still completes, with DONE at cycle 11.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller: datapath
// widths, SRAM geometry, the memory map base and the controller state encoding.
package mem_access_ctrl_pkg;

  // Core datapath widths used across the pipeline.
  localparam int ADDRESS_LEN  = 32;
  localparam int REGISTER_LEN = 32;

  // External SRAM geometry: 16-bit half-words, 18-bit half-word address.
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_IDX_W  = SRAM_ADDR_W - 1;  // word index; LSB picks the half

  // Byte address that maps to SRAM word 0.
  localparam int SRAM_BASE_ADDR = 1024;

  // Each 32-bit access is split into a low half-word and a high half-word phase.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // True while the controller is actively strobing the SRAM.
  function automatic logic is_active(input state_t s);
    return (s == LO) || (s == HI);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter: counts cycles spent in one SRAM phase and flags the
// last one. WAIT_CYCLES must lie in 1..15 to fit the 4-bit count.
module wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [3:0] count;

  // Count up while enabled; clear restarts the phase at zero.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign done = enable && (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller. Splits each 32-bit load/store into two
// 16-bit SRAM accesses (low half, then high half), each held for WAIT_CYCLES
// cycles, and stalls the pipeline through ready while the access is in flight.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDRESS_LEN,
  parameter int DATA_W      = REGISTER_LEN,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [ADDR_W-1:0]      alu_res_in,
  input  logic [DATA_W-1:0]      val_rm_in,
  output logic                   ready,
  output logic [DATA_W-1:0]      data_mem_out,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_wdata,
  input  logic [SRAM_DATA_W-1:0] sram_rdata,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  state_t                    state, state_next;
  logic                      req;
  logic                      cnt_clear, cnt_enable, cnt_done;
  logic                      is_write_q;
  logic [SRAM_IDX_W-1:0]     idx_q;
  logic [2*SRAM_DATA_W-1:0]  wdata_q;
  logic [SRAM_DATA_W-1:0]    rdata_lo_q;

  // A simultaneous read and write request is treated as a write.
  assign req = mem_read_in | mem_write_in;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each half-word phase ends on the counter's last cycle.
  // NOTE: every signal written in always_comb gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req)      state_next = LO;
      LO:      if (cnt_done) state_next = HI;
      HI:      if (cnt_done) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // The counter restarts on every state change, so each phase starts at zero.
  assign cnt_clear  = (state_next != state);
  assign cnt_enable = is_active(state);

  wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .done   (cnt_done)
  );

  // Latch operands when an access is accepted, so the MEM stage may change or
  // drop its request while the access runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else if ((state == IDLE) && req) begin
      idx_q      <= SRAM_IDX_W'((alu_res_in - ADDR_W'(BASE_ADDR)) >> 2);
      wdata_q    <= val_rm_in[2*SRAM_DATA_W-1:0];
      is_write_q <= mem_write_in;
    end
  end

  // Capture read data on the last cycle of each phase. The low half is staged
  // so the visible result only changes once the whole word has been read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_lo_q   <= '0;
      data_mem_out <= '0;
    end else if (cnt_done && !is_write_q) begin
      if (state == LO) begin
        rdata_lo_q <= sram_rdata;
      end else if (state == HI) begin
        data_mem_out <= DATA_W'({sram_rdata, rdata_lo_q});
      end
    end
  end

  // SRAM strobes and bus: idle-safe values outside the two access phases.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    if (is_active(state)) begin
      sram_addr = {idx_q, (state == HI)};
      if (is_write_q) begin
        sram_we_n  = 1'b0;
        sram_wdata = (state == HI) ? wdata_q[2*SRAM_DATA_W-1:SRAM_DATA_W]
                                   : wdata_q[SRAM_DATA_W-1:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  // The pipeline may advance when the access has finished or none is pending.
  assign ready = (state == DONE) || ((state == IDLE) && !req);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a table of directed accesses run
// back-to-back against a small SRAM model, plus a mid-access reset sequence.
module tb_mem_access_ctrl;

  localparam int W = 5;  // WAIT_CYCLES

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic        ready;
  logic [31:0] dout;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        we_n, oe_n;

  logic [15:0] mem [64];
  logic        preload;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] held;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .WAIT_CYCLES (W),
    .BASE_ADDR   (1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_in  (rd),
    .mem_write_in (wr),
    .alu_res_in   (addr),
    .val_rm_in    (wdata),
    .ready        (ready),
    .data_mem_out (dout),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_we_n    (we_n),
    .sram_oe_n    (oe_n)
  );

  // SRAM model: asynchronous read, write on the clock edge while we_n is low.
  assign sram_rdata = mem[sram_addr[5:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[2] <= 16'h5678;
      mem[3] <= 16'h1234;
      mem[8] <= 16'hCAFE;
      mem[9] <= 16'hBABE;
    end else if (!we_n) begin
      mem[sram_addr[5:0]] <= sram_wdata;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [16:0] idx;   // expected SRAM word index
    logic [15:0] wlo;   // expected write data in LO
    logic [15:0] whi;   // expected write data in HI
    logic [31:0] dout;  // expected data_mem_out in DONE and afterwards
    int          drop;  // cycle at which the request is withdrawn (0 = never)
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one access: cycle 0 is IDLE with the request, 1..W is LO,
  // W+1..2W is HI, 2W+1 is DONE. Every cycle is checked in full.
  task automatic run_access(input int n, input vec_t v);
    logic        lo, hi, dn;
    logic [17:0] exp_addr;
    logic [15:0] exp_wd;
    for (int c = 0; c <= 2*W + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.data;
      end
      if (v.drop != 0 && c == v.drop) begin
        rd = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'h0;
      end
      #1;
      lo = (c >= 1) && (c <= W);
      hi = (c > W) && (c <= 2*W);
      dn = (c == 2*W + 1);
      exp_addr = lo ? {v.idx, 1'b0} : (hi ? {v.idx, 1'b1} : 18'd0);
      exp_wd   = (v.wr && lo) ? v.wlo : ((v.wr && hi) ? v.whi : 16'h0);
      check($sformatf("v%0d c%0d ready", n, c), 32'(ready), 32'(dn));
      check($sformatf("v%0d c%0d sram_addr", n, c), 32'(sram_addr), 32'(exp_addr));
      check($sformatf("v%0d c%0d we_n", n, c), 32'(we_n), 32'(!(v.wr && (lo || hi))));
      check($sformatf("v%0d c%0d oe_n", n, c), 32'(oe_n), 32'(!(!v.wr && (lo || hi))));
      check($sformatf("v%0d c%0d wdata", n, c), 32'(sram_wdata), 32'(exp_wd));
      check($sformatf("v%0d c%0d data_out", n, c), dout, dn ? v.dout : held);
    end
    held = v.dout;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    //          rd    wr    addr        data          idx        wlo       whi       dout          drop
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0,     16'hBEEF, 16'hDEAD, 32'h00000000, 0};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 17'd1,     16'h0000, 16'h0000, 32'h12345678, 0};
    vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'hA5A50F0F, 17'd2,     16'h0F0F, 16'hA5A5, 32'h12345678, 0};
    vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h00000000, 17'd4,     16'h0000, 16'h0000, 32'hBABECAFE, 2};
    vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 17'd0,     16'h0000, 16'h0000, 32'hDEADBEEF, 0};
    vecs[5] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 17'd2,     16'h0000, 16'h0000, 32'hA5A50F0F, 0};
    vecs[6] = '{1'b1, 1'b0, 32'd0,    32'h00000000, 17'h1FF00, 16'h0000, 16'h0000, 32'hDEADBEEF, 0};
    vecs[7] = '{1'b0, 1'b1, 32'd1028, 32'h00C0FFEE, 17'd1,     16'hFFEE, 16'h00C0, 32'hDEADBEEF, 0};

    rst = 1'b1; preload = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    held = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset we_n", 32'(we_n), 32'd1);
    check("reset oe_n", 32'(oe_n), 32'd1);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    check("reset data_out", dout, 32'd0);
    preload = 1'b0;
    rst = 1'b0;

    // Directed accesses, issued back-to-back.
    for (int i = 0; i < 8; i++) run_access(i, vecs[i]);

    // Reset on the 3rd cycle of HI during a write.
    for (int c = 0; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        wr = 1'b1; addr = 32'd1036; wdata = 32'h11112222;
      end
    end
    #1;
    check("hi3 we_n", 32'(we_n), 32'd0);
    check("hi3 sram_addr", 32'(sram_addr), 32'd7);
    rst = 1'b1;
    #1;
    check("rst we_n", 32'(we_n), 32'd1);
    check("rst oe_n", 32'(oe_n), 32'd1);
    check("rst sram_addr", 32'(sram_addr), 32'd0);
    check("rst data_out", dout, 32'd0);
    check("rst ready req1", 32'(ready), 32'd0);
    wr = 1'b0;
    #1;
    check("rst ready req0", 32'(ready), 32'd1);
    held = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst c%0d ready", c), 32'(ready), 32'd1);
      check($sformatf("post-rst c%0d we_n", c), 32'(we_n), 32'd1);
      check($sformatf("post-rst c%0d sram_addr", c), 32'(sram_addr), 32'd0);
    end

    // The controller works again after reset and sees the earlier store.
    run_access(8, '{1'b1, 1'b0, 32'd1028, 32'h0, 17'd1, 16'h0, 16'h0, 32'h00C0FFEE, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
